// File: rtl/addsub_issue_ctrl_if.sv
// addsub_issue_ctrl_if: issue handshake, adder drive/return and result handshake bundle.
interface addsub_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        add_sub;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_rd, result, out_ready,
        output in_ready, add_sub, dataa, datab, out_valid, out_data, out_rd
    );
    modport master (
        output in_valid, in_op, in_a, in_b, in_rd, result, out_ready,
        input  in_ready, add_sub, dataa, datab, out_valid, out_data, out_rd
    );
endinterface

// File: rtl/addsub_issue_ctrl.sv
// addsub_issue_ctrl: issues ADD/SUB/SLT/SLTU into a fixed-latency adder and retires
// results in order through a credit-guarded output FIFO.
module addsub_issue_ctrl #(
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input logic                 clk,
    input logic                 AReset,
    addsub_issue_ctrl_if.slave  bus
);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH + LAT + 2);
    typedef struct packed {
        logic       v;
        logic [1:0] op;
        logic [4:0] rd;
        logic       a31;
        logic       b31;
    } meta_t;
    meta_t       meta_q [LAT+1];
    meta_t       meta_d [LAT+1];
    logic [31:0] dataa_q, dataa_d, datab_q, datab_d;
    logic        add_sub_q, add_sub_d;
    logic [31:0] data_q [DEPTH];
    logic [31:0] data_d [DEPTH];
    logic [4:0]  rd_q [DEPTH];
    logic [4:0]  rd_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] occ;
    logic          accept, push, pop, lt;
    logic [31:0]   push_data;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    // Credits cover every valid pipeline stage, so a retire always finds room.
    always_comb begin
        occ = SW'(cnt_q);
        for (int i = 0; i <= LAT; i++) occ = occ + SW'(meta_q[i].v);
    end
    assign bus.in_ready  = occ < SW'(DEPTH);
    assign accept        = bus.in_valid & bus.in_ready;
    assign push          = meta_q[LAT].v;
    assign pop           = (cnt_q != '0) & bus.out_ready;
    // Operand signs decide when they differ; otherwise the difference sign is exact.
    assign lt            = meta_q[LAT].a31 != meta_q[LAT].b31
                         ? (meta_q[LAT].op[0] ? meta_q[LAT].b31 : meta_q[LAT].a31)
                         : bus.result[31];
    assign push_data     = meta_q[LAT].op[1] ? {31'b0, lt} : bus.result;
    always_comb begin
        dataa_d   = accept ? bus.in_a : dataa_q;
        datab_d   = accept ? bus.in_b : datab_q;
        add_sub_d = accept ? bus.in_op == OP_ADD : add_sub_q;
        meta_d[0] = '{v: accept, op: bus.in_op, rd: bus.in_rd, a31: bus.in_a[31], b31: bus.in_b[31]};
        for (int i = 1; i <= LAT; i++) meta_d[i] = meta_q[i-1];
        data_d = data_q;
        rd_d   = rd_q;
        if (push) begin
            data_d[tail_q] = push_data;
            rd_d[tail_q]   = meta_q[LAT].rd;
        end
        tail_d = push ? nxt(tail_q) : tail_q;
        head_d = pop ? nxt(head_q) : head_q;
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk or negedge AReset) begin
        if (!AReset) begin
            dataa_q   <= '0;
            datab_q   <= '0;
            add_sub_q <= 1'b1;
            for (int i = 0; i <= LAT; i++) meta_q[i] <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                rd_q[i]   <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            dataa_q   <= dataa_d;
            datab_q   <= datab_d;
            add_sub_q <= add_sub_d;
            meta_q    <= meta_d;
            data_q    <= data_d;
            rd_q      <= rd_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
        end
    end
    assign bus.dataa     = dataa_q;
    assign bus.datab     = datab_q;
    assign bus.add_sub   = add_sub_q;
    assign bus.out_valid = cnt_q != '0;
    assign bus.out_data  = data_q[head_q];
    assign bus.out_rd    = rd_q[head_q];
endmodule
